// File: rtl/gpio_input_conditioner.sv
// gpio_input_conditioner: synchronises GPIO pins, optionally debounces them (GPIO_INPUT_DEBOUNCE_EN) and latches edge interrupts
module gpio_input_conditioner #(
  parameter int WIDTH = 32,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] gpio_pin_input,
  input  logic [WIDTH-1:0] rise_enable,
  input  logic [WIDTH-1:0] fall_enable,
  input  logic [WIDTH-1:0] irq_clear,
  output logic [WIDTH-1:0] gpio_value,
  output logic [WIDTH-1:0] irq_pending,
  output logic             irq_output
);
  logic [WIDTH-1:0] s1, s2, gv_next;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= gpio_pin_input;
      s2 <= s1;
    end
`ifdef GPIO_INPUT_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [WIDTH-1:0][CW-1:0] cnt;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else
      for (int b = 0; b < WIDTH; b++)
        cnt[b] <= (s2[b] != gpio_value[b] && cnt[b] != LAST) ? cnt[b] + 1'b1 : '0;
  always_comb
    for (int b = 0; b < WIDTH; b++)
      gv_next[b] = (s2[b] != gpio_value[b] && cnt[b] == LAST) ? s2[b] : gpio_value[b];
`else
  assign gv_next = s2;
`endif
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      gpio_value  <= '0;
      irq_pending <= '0;
    end else begin
      gpio_value  <= gv_next;
      irq_pending <= (gv_next & ~gpio_value & rise_enable) | (~gv_next & gpio_value & fall_enable) |
                     (irq_pending & ~irq_clear);
    end
  assign irq_output = |irq_pending;
endmodule
